// File: rtl/mux8_scan_serializer.sv
// rtl/mux8_scan_serializer.sv - drives an 8:1 mux through all select codes and serializes/checks its output
module mux8_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       I0,
    output logic       I1,
    output logic       I2,
    output logic       I3,
    output logic       I4,
    output logic       I5,
    output logic       I6,
    output logic       I7,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    input  logic       y_in,
    output logic       dout,
    output logic       dout_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] FIRST_INDEX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_INDEX  = MSB_FIRST ? 3'd0 : 3'd7;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] word;
    logic [2:0] index;
    logic       last_sample;

    assign last_sample = (index == LAST_INDEX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last_sample) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SCAN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // y_in is the live mux return for the current select code, sampled at each SCAN edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word       <= 8'h00;
            index      <= 3'd0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    if (start) begin
                        word    <= din;
                        index   <= FIRST_INDEX;
                        err     <= 1'b0;
                        err_cnt <= 4'd0;
                    end
                end
                SCAN: begin
                    dout       <= y_in;
                    dout_valid <= 1'b1;
                    if (y_in != word[index]) begin
                        err     <= 1'b1;
                        err_cnt <= err_cnt + 4'd1;
                    end
                    // selects hold the final code through DONE
                    if (!last_sample) begin
                        index <= MSB_FIRST ? index - 3'd1 : index + 3'd1;
                    end
                end
                DONE: dout_valid <= 1'b0;
                default: dout_valid <= 1'b0;
            endcase
        end
    end

    assign I0 = word[0];
    assign I1 = word[1];
    assign I2 = word[2];
    assign I3 = word[3];
    assign I4 = word[4];
    assign I5 = word[5];
    assign I6 = word[6];
    assign I7 = word[7];
    assign S1 = index[2];
    assign S2 = index[1];
    assign S3 = index[0];

endmodule
